// File: rtl/serial_port_scheduler.sv
// serial_port_scheduler: round-robin arbiter for two byte requesters onto one
// serial transmitter with timer-enforced frame spacing, plus a receive hold
// register with valid/ack handshake and sticky overrun flag.
//
// Handshakes: reqN is held with stable dataN until a one-cycle ackN pulse;
// rx_valid stays high until rx_ack is seen in a cycle with no new byte.
module serial_port_scheduler #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FRAME_BITS   = 10,
    parameter int START_LEN    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       start_send,
    output logic [7:0] tx_data,
    output logic       tx_busy,
    input  logic       rx_finished,
    input  logic [7:0] rx_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_overrun,
    output logic [1:0] dbg_state
);

    localparam int FRAME = CLKS_PER_BIT * FRAME_BITS;
    localparam int CW    = $clog2(FRAME + 1);

    localparam logic [CW-1:0] START_LEN_C = CW'(START_LEN);
    localparam logic [CW-1:0] FRAME_C     = CW'(FRAME);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_rr_last;
    logic          r_rx_fin_prev;

    logic          w_any_req;
    logic          w_grant;
    logic          w_rx_rise;

    assign w_any_req = req0 | req1;
    // With both requesting, the one not served last wins; otherwise the lone requester.
    assign w_grant   = (req0 & req1) ? ~r_rr_last : req1;
    assign w_rx_rise = rx_finished & ~r_rx_fin_prev;
    assign dbg_state = r_state;

    // Transmit sequencer: grant, hold the start strobe, then time out the rest of the frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rr_last  <= 1'b1;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            start_send <= 1'b0;
            tx_busy    <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        tx_data    <= w_grant ? data1 : data0;
                        ack0       <= ~w_grant;
                        ack1       <= w_grant;
                        start_send <= 1'b1;
                        tx_busy    <= 1'b1;
                        r_rr_last  <= w_grant;
                        r_cnt      <= CNT_ONE;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt >= START_LEN_C) begin
                        start_send <= 1'b0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    // The frame timer stands in for the transmitter's missing busy output.
                    if (r_cnt >= FRAME_C) begin
                        tx_busy <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Receive capture: load on the rising edge of rx_finished, flag overwrites of unconsumed bytes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_fin_prev <= 1'b1;
            rx_byte       <= 8'h00;
            rx_valid      <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            r_rx_fin_prev <= rx_finished;
            if (w_rx_rise) begin
                rx_byte  <= rx_data;
                rx_valid <= 1'b1;
                if (rx_valid && !rx_ack) begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_port_scheduler.sv
// Testbench for serial_port_scheduler: directed vectors, expected grants and
// receive-register states pushed into queues, checked by a negedge monitor.
module tb_serial_port_scheduler;

    localparam int CLKS_PER_BIT = 4;
    localparam int FRAME_BITS   = 10;
    localparam int START_LEN    = 1;
    localparam int FRAME        = CLKS_PER_BIT * FRAME_BITS;

    logic       clk;
    logic       rst_n;
    logic       req0;
    logic [7:0] data0;
    logic       ack0;
    logic       req1;
    logic [7:0] data1;
    logic       ack1;
    logic       start_send;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       rx_finished;
    logic [7:0] rx_data;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_overrun;
    logic [1:0] dbg_state;

    // {ack1, ack0, tx_data} expected at each grant
    logic [9:0] tx_exp_q[$];
    // {rx_overrun, rx_valid, rx_byte} expected after a receive-side edge
    logic [9:0] rx_exp_q[$];

    int n_vec;
    int n_err;
    bit chk_gap;

    serial_port_scheduler #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .FRAME_BITS  (FRAME_BITS),
        .START_LEN   (START_LEN)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .req0       (req0),
        .data0      (data0),
        .ack0       (ack0),
        .req1       (req1),
        .data1      (data1),
        .ack1       (ack1),
        .start_send (start_send),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .rx_finished(rx_finished),
        .rx_data    (rx_data),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .rx_overrun (rx_overrun),
        .dbg_state  (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_start_send", start_send, 0);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_overrun", rx_overrun, 0);
        check("rst_rx_byte", rx_byte, 0);
        check("rst_state", dbg_state, 0);
        tx_exp_q.delete();
        rx_exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            if (ack0 || ack1) seen = 1'b1;
        end
        if (!seen) check({name, "_ack_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < budget && !idle; i++) begin
            @(posedge clk);
            #1;
            if (!tx_busy) idle = 1'b1;
        end
        if (!idle) check("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic rx_pulse(input logic [7:0] d, input logic ack, input logic [9:0] exp);
        @(posedge clk);
        #1;
        rx_data     = d;
        rx_finished = 1'b1;
        rx_ack      = ack;
        @(posedge clk);
        #1;
        rx_exp_q.push_back(exp);
        rx_finished = 1'b0;
        rx_ack      = 1'b0;
    endtask

    task automatic rx_step(input logic ack, input logic [9:0] exp);
        @(posedge clk);
        #1;
        rx_ack = ack;
        @(posedge clk);
        #1;
        rx_exp_q.push_back(exp);
        rx_ack = 1'b0;
    endtask

    // Monitor / scoreboard: compares whatever the DUT presents against the queues
    int         cyc;
    int         last_rise;
    bit         have_last;
    bit         prev_ack;
    bit         prev_ss;
    bit         prev_busy;
    int         busy_run;
    logic [7:0] held_data;
    logic [9:0] exp_v;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ack  = 1'b0;
            prev_ss   = 1'b0;
            prev_busy = 1'b0;
            busy_run  = 0;
            have_last = 1'b0;
            held_data = 8'h00;
        end else begin
            cyc++;
            if (ack0 || ack1) begin
                if (tx_exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL grant_unexpected: got %0h expected none", {ack1, ack0, tx_data});
                end else begin
                    exp_v = tx_exp_q.pop_front();
                    check("grant", {22'd0, ack1, ack0, tx_data}, {22'd0, exp_v});
                end
                check("start_with_ack", start_send, 1);
                check("idle_before_grant", prev_busy, 0);
                held_data = tx_data;
            end else begin
                check("tx_data_hold", tx_data, held_data);
            end
            if (prev_ack) check("ack_width", {ack1, ack0}, 0);
            if (prev_ss) check("start_width", start_send, 0);
            if (start_send && !prev_ss) begin
                if (chk_gap && have_last) check("start_gap", cyc - last_rise, FRAME + 1);
                last_rise = cyc;
                have_last = 1'b1;
            end
            if (tx_busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                check("busy_len", busy_run, FRAME);
                busy_run = 0;
            end
            prev_ack  = ack0 | ack1;
            prev_ss   = start_send;
            prev_busy = tx_busy;
            if (rx_exp_q.size() != 0) begin
                exp_v = rx_exp_q.pop_front();
                check("rx_state", {22'd0, rx_overrun, rx_valid, rx_byte}, {22'd0, exp_v});
            end
        end
    end

    // Directed stimulus
    initial begin
        n_vec       = 0;
        n_err       = 0;
        cyc         = 0;
        last_rise   = 0;
        chk_gap     = 1'b0;
        rst_n       = 1'b0;
        req0        = 1'b0;
        req1        = 1'b0;
        data0       = 8'h00;
        data1       = 8'h00;
        rx_finished = 1'b0;
        rx_data     = 8'h00;
        rx_ack      = 1'b0;

        // single request: one grant, 40-cycle frame
        apply_reset();
        req0  = 1'b1;
        data0 = 8'hA5;
        tx_exp_q.push_back({2'b01, 8'hA5});
        wait_ack("single", 10);
        req0 = 1'b0;
        wait_idle(FRAME + 10);

        // both held: round-robin 0x11, 0x22, 0x11 spaced FRAME+1 apart
        apply_reset();
        chk_gap = 1'b1;
        req0  = 1'b1;
        data0 = 8'h11;
        req1  = 1'b1;
        data1 = 8'h22;
        tx_exp_q.push_back({2'b01, 8'h11});
        tx_exp_q.push_back({2'b10, 8'h22});
        tx_exp_q.push_back({2'b01, 8'h11});
        for (int k = 0; k < 3; k++) wait_ack("rr", FRAME + 10);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle(FRAME + 10);

        // req1 arrives mid-frame: must wait for the frame to end
        apply_reset();
        req0  = 1'b1;
        data0 = 8'h11;
        tx_exp_q.push_back({2'b01, 8'h11});
        wait_ack("mid0", 10);
        req0 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        req1  = 1'b1;
        data1 = 8'h22;
        tx_exp_q.push_back({2'b10, 8'h22});
        wait_ack("mid1", FRAME + 10);
        req1 = 1'b0;
        wait_idle(FRAME + 10);
        chk_gap = 1'b0;

        // reset five cycles into a frame aborts it; next frame is full length
        apply_reset();
        req0  = 1'b1;
        data0 = 8'h5A;
        tx_exp_q.push_back({2'b01, 8'h5A});
        wait_ack("abort", 10);
        req0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("busy_before_abort", tx_busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_start_send", start_send, 0);
        check("abort_tx_busy", tx_busy, 0);
        check("abort_acks", {ack1, ack0}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req0  = 1'b1;
        data0 = 8'h77;
        tx_exp_q.push_back({2'b01, 8'h77});
        wait_ack("after_abort", 10);
        req0 = 1'b0;
        wait_idle(FRAME + 10);

        // receive capture, overwrite with overrun, coincident rise and ack
        apply_reset();
        rx_pulse(8'h3C, 1'b0, {1'b0, 1'b1, 8'h3C});
        rx_pulse(8'h7E, 1'b0, {1'b1, 1'b1, 8'h7E});
        rx_pulse(8'hC3, 1'b1, {1'b1, 1'b1, 8'hC3});
        rx_step(1'b1, {1'b1, 1'b0, 8'hC3});
        apply_reset();
        rx_pulse(8'h3C, 1'b0, {1'b0, 1'b1, 8'h3C});
        rx_pulse(8'h55, 1'b1, {1'b0, 1'b1, 8'h55});
        rx_step(1'b1, {1'b0, 1'b0, 8'h55});
        rx_step(1'b1, {1'b0, 1'b0, 8'h55});
        rx_step(1'b0, {1'b0, 1'b0, 8'h55});

        // receive and transmit active together
        req1  = 1'b1;
        data1 = 8'hE7;
        tx_exp_q.push_back({2'b10, 8'hE7});
        rx_pulse(8'h9A, 1'b0, {1'b0, 1'b1, 8'h9A});
        req1 = 1'b0;
        wait_idle(FRAME + 10);

        // rx_finished high across reset release: no capture until fall and rise
        rx_finished = 1'b1;
        rx_data     = 8'h99;
        apply_reset();
        rx_step(1'b0, {1'b0, 1'b0, 8'h00});
        rx_step(1'b0, {1'b0, 1'b0, 8'h00});
        @(posedge clk);
        #1;
        rx_finished = 1'b0;
        @(posedge clk);
        #1;
        rx_finished = 1'b1;
        rx_data     = 8'h66;
        @(posedge clk);
        #1;
        rx_exp_q.push_back({1'b0, 1'b1, 8'h66});
        rx_data = 8'h12;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            rx_exp_q.push_back({1'b0, 1'b1, 8'h66});
        end
        rx_finished = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("tx_queue_drained", tx_exp_q.size(), 0);
        check("rx_queue_drained", rx_exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
